// File: rtl/wbm_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
package wbm_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0]  SEL_ALL  = 4'hF;
  localparam logic [31:0] ADR_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wbm_timeout.sv
// Per-access ack watchdog: counts cycles spent waiting in one bus access.
module wbm_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Expires on the TIMEOUT-th waiting cycle, so the access lasts exactly TIMEOUT cycles.
  assign o_expired = i_run && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wbm_block_copy.sv
// Wishbone initiator copying a block of words, one read then one write per word.
// Optional per-access ack timeout enabled by defining WBM_TIMEOUT_EN.
module wbm_block_copy
  import wbm_copy_pkg::*;
#(
  parameter int unsigned BITS    = 32,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [BITS-1:0]  wbm_dat_o,
  input  logic [BITS-1:0]  wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words;
  logic [BITS-1:0]   r_buf;
  logic              r_cyc;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_adr;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_in_acc;
  logic              w_enter_acc;
  logic              w_timeout;
  logic [31:0]       w_src_nx;

  assign w_accept    = (r_state == IDLE) && start_i;
  assign w_in_acc    = (r_state == RD) || (r_state == WR);
  assign w_enter_acc = ((w_next == RD) || (w_next == WR)) && (w_next != r_state);
  assign w_src_nx    = w_accept ? word_align(src_adr_i) : r_src;

`ifdef WBM_TIMEOUT_EN
  logic r_err;

  wbm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_n_i),
    .i_clr     (w_enter_acc),
    .i_run     (w_in_acc && !wbm_ack_i),
    .o_expired (w_timeout)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_next == ERR) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start_i) w_next = (len_i == '0) ? DONE : RD;
      RD: begin
        if (wbm_ack_i)      w_next = RGAP;
        else if (w_timeout) w_next = ERR;
      end
      RGAP: w_next = WR;
      WR: begin
        if (wbm_ack_i)      w_next = WGAP;
        else if (w_timeout) w_next = ERR;
      end
      WGAP:    w_next = (r_words < r_len) ? RD : DONE;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: pointers, count and buffer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_buf   <= '0;
    end else begin
      if (w_accept) begin
        r_src   <= word_align(src_adr_i);
        r_dst   <= word_align(dst_adr_i);
        r_len   <= len_i;
        r_words <= '0;
      end
      if ((r_state == RD) && wbm_ack_i) begin
        r_buf <= wbm_dat_i;
      end
      if ((r_state == WR) && wbm_ack_i) begin
        r_words <= r_words + 1'b1;
        r_src   <= r_src + ADR_STEP;
        r_dst   <= r_dst + ADR_STEP;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_adr  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cyc  <= (w_next == RD) || (w_next == WR);
      r_we   <= (w_next == WR);
      r_sel  <= ((w_next == RD) || (w_next == WR)) ? SEL_ALL : '0;
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE) || (w_next == ERR);
      if (w_next == RD)      r_adr <= w_src_nx;
      else if (w_next == WR) r_adr <= r_dst;
      else                   r_adr <= '0;
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign words_done_o = r_words;
  assign wbm_cyc_o    = r_cyc;
  assign wbm_stb_o    = r_cyc;
  assign wbm_we_o     = r_we;
  assign wbm_sel_o    = r_sel;
  assign wbm_adr_o    = r_adr;
  assign wbm_dat_o    = r_buf;

endmodule
